// File: rtl/trace_cmd_dispatch.sv
// Trace command dispatcher: buffers (cmd, addr) pairs, drops illegal codes and issues decoded LLC requests.
// Optional statistics counters and the clear barrier are built when TRACE_DISPATCH_STATS_EN is defined.
module trace_cmd_dispatch #(
  parameter int ADDR_W      = 32,
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 14,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 32,
  localparam int TAG_BITS   = ADDR_W - INDEX_BITS - OFFSET_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_cmd,
  input  logic [ADDR_W-1:0]      in_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_cmd,
  output logic [TAG_BITS-1:0]    out_tag,
  output logic [INDEX_BITS-1:0]  out_index,
  output logic [OFFSET_BITS-1:0] out_offset,
  output logic                   out_snoop,
  output logic                   out_clear,
  output logic                   out_print,
  output logic                   err_cmd,
  output logic [CNT_W-1:0]       cnt_reads,
  output logic [CNT_W-1:0]       cnt_writes,
  output logic [CNT_W-1:0]       cnt_snoops,
  output logic [CNT_W-1:0]       cnt_errs
);

  localparam int PTR_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = 4 + ADDR_W;

  typedef enum logic {S_EMPTY, S_LOADED} slot_state_t;

  slot_state_t state, state_next;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               fifo_full, fifo_empty;
  logic               in_acc, in_legal, push, pop;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;
  logic [3:0]         slot_cmd;
  logic [ADDR_W-1:0]  slot_addr;

  function automatic logic is_legal(input logic [3:0] c);
    return (c <= 4'd6) || (c == 4'd8) || (c == 4'd9);
  endfunction

  function automatic logic is_snoop(input logic [3:0] c);
    return (c >= 4'd3) && (c <= 4'd6);
  endfunction

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                      (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
  // Depends only on pointers, so in_ready never combinationally follows out_ready.
  assign in_ready   = !fifo_full;
  assign in_acc     = in_valid && in_ready;
  assign in_legal   = is_legal(in_cmd);
  assign push       = in_acc && in_legal;

  // Clear/print carry no address; zero it at enqueue so the slot needs no special case.
  always_comb begin
    wr_entry = {in_cmd, in_addr};
    if ((in_cmd == 4'd8) || (in_cmd == 4'd9))
      wr_entry = {in_cmd, {ADDR_W{1'b0}}};
  end

  assign rd_entry = mem[rd_ptr[PTR_W-2:0]];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[PTR_W-2:0]] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      err_cmd <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      err_cmd <= in_acc && !in_legal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_EMPTY;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_EMPTY:  if (!fifo_empty) state_next = S_LOADED;
      S_LOADED: if (out_ready && fifo_empty) state_next = S_EMPTY;
      default:  state_next = S_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    pop       = 1'b0;
    unique case (state)
      S_EMPTY:  pop = !fifo_empty;
      S_LOADED: begin
        out_valid = 1'b1;
        pop       = out_ready && !fifo_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cmd  <= '0;
      slot_addr <= '0;
    end else if (pop) begin
      slot_cmd  <= rd_entry[ENTRY_W-1 -: 4];
      slot_addr <= rd_entry[ADDR_W-1:0];
    end
  end

  assign out_cmd    = slot_cmd;
  assign out_tag    = slot_addr[ADDR_W-1 -: TAG_BITS];
  assign out_index  = slot_addr[OFFSET_BITS +: INDEX_BITS];
  assign out_offset = slot_addr[OFFSET_BITS-1:0];
  assign out_snoop  = out_valid && is_snoop(slot_cmd);
  assign out_clear  = out_valid && (slot_cmd == 4'd8);
  assign out_print  = out_valid && (slot_cmd == 4'd9);

`ifdef TRACE_DISPATCH_STATS_EN
  logic             out_hs;
  logic [CNT_W-1:0] reads_q, writes_q, snoops_q, errs_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  assign out_hs = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reads_q  <= '0;
      writes_q <= '0;
      snoops_q <= '0;
      errs_q   <= '0;
    end else begin
      if (out_hs) begin
        if (slot_cmd == 4'd8) begin
          reads_q  <= '0;
          writes_q <= '0;
          snoops_q <= '0;
        end else if ((slot_cmd == 4'd0) || (slot_cmd == 4'd2)) begin
          reads_q <= sat_inc(reads_q);
        end else if (slot_cmd == 4'd1) begin
          writes_q <= sat_inc(writes_q);
        end else if (is_snoop(slot_cmd)) begin
          snoops_q <= sat_inc(snoops_q);
        end
      end
      if (in_acc && !in_legal)
        errs_q <= sat_inc(errs_q);
    end
  end

  assign cnt_reads  = reads_q;
  assign cnt_writes = writes_q;
  assign cnt_snoops = snoops_q;
  assign cnt_errs   = errs_q;
`else
  assign cnt_reads  = '0;
  assign cnt_writes = '0;
  assign cnt_snoops = '0;
  assign cnt_errs   = '0;
`endif

endmodule

// File: tb/tb_trace_cmd_dispatch.sv
// Self-checking bench for trace_cmd_dispatch: directed scenarios plus random traffic against a queue model.
module tb_trace_cmd_dispatch;

  localparam int ADDR_W = 32;
  localparam int OFF    = 6;
  localparam int IDX    = 14;
  localparam int TAGW   = ADDR_W - IDX - OFF;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_cmd;
  logic [ADDR_W-1:0] in_addr;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_cmd;
  logic [TAGW-1:0]   out_tag;
  logic [IDX-1:0]    out_index;
  logic [OFF-1:0]    out_offset;
  logic              out_snoop, out_clear, out_print, err_cmd;
  logic [CNT_W-1:0]  cnt_reads, cnt_writes, cnt_snoops, cnt_errs;

  trace_cmd_dispatch #(
    .ADDR_W(ADDR_W), .OFFSET_BITS(OFF), .INDEX_BITS(IDX), .DEPTH(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd),
    .out_tag(out_tag), .out_index(out_index), .out_offset(out_offset),
    .out_snoop(out_snoop), .out_clear(out_clear), .out_print(out_print),
    .err_cmd(err_cmd),
    .cnt_reads(cnt_reads), .cnt_writes(cnt_writes), .cnt_snoops(cnt_snoops), .cnt_errs(cnt_errs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      cmd;
    logic [TAGW-1:0] tag;
    logic [IDX-1:0]  idx;
    logic [OFF-1:0]  off;
  } req_t;

  req_t q[$];
  int   m_reads, m_writes, m_snoops, m_errs;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt(input int m);
`ifdef TRACE_DISPATCH_STATS_EN
    return m;
`else
    return 0 * m;
`endif
  endfunction

  function automatic logic legal(input logic [3:0] c);
    return c inside {[0:6], 8, 9};
  endfunction

  function automatic req_t decode(input logic [3:0] c, input logic [31:0] a);
    req_t r;
    r.cmd = c;
    if (c == 8 || c == 9) begin
      r.tag = '0; r.idx = '0; r.off = '0;
    end else begin
      r.tag = TAGW'(a >> (OFF + IDX));
      r.idx = IDX'((a >> OFF) % (32'd1 << IDX));
      r.off = OFF'(a % (32'd1 << OFF));
    end
    return r;
  endfunction

  function automatic int sat(input int m);
    return (m < CMAX) ? m + 1 : m;
  endfunction

  function automatic logic [3:0] rand_legal();
    logic [3:0] c;
    c = 4'($urandom_range(0, 8));
    if (c == 7) c = 9;
    return c;
  endfunction

  // One clock: drive at the falling edge, sample before the rising edge, check after it.
  task automatic cycle(input logic v, input logic [3:0] c, input logic [31:0] a,
                       input logic ordy, output logic rdy, output logic hs);
    logic exp_err;
    req_t r;
    in_valid = v; in_cmd = c; in_addr = a; out_ready = ordy;
    #1;
    rdy = in_ready;
    hs  = out_valid && ordy;
    if (!out_valid) begin
      chk("flags_idle", {out_snoop, out_clear, out_print}, 3'b000);
    end else if (q.size() == 0) begin
      chk("spurious_valid", out_valid, 1'b0);
    end else begin
      r = q[0];
      chk("out_cmd", out_cmd, r.cmd);
      chk("out_tag", out_tag, r.tag);
      chk("out_index", out_index, r.idx);
      chk("out_offset", out_offset, r.off);
      chk("flags", {out_snoop, out_clear, out_print},
          {r.cmd >= 3 && r.cmd <= 6, r.cmd == 8, r.cmd == 9});
      if (hs) begin
        void'(q.pop_front());
        if (r.cmd == 8) begin
          m_reads = 0; m_writes = 0; m_snoops = 0;
        end else if (r.cmd == 0 || r.cmd == 2) m_reads = sat(m_reads);
        else if (r.cmd == 1) m_writes = sat(m_writes);
        else if (r.cmd >= 3 && r.cmd <= 6) m_snoops = sat(m_snoops);
      end
    end
    exp_err = v && rdy && !legal(c);
    if (v && rdy) begin
      if (legal(c)) q.push_back(decode(c, a));
      else m_errs = sat(m_errs);
    end
    @(posedge clk);
    @(negedge clk);
    chk("err_cmd", err_cmd, exp_err);
    chk("cnt_reads", cnt_reads, exp_cnt(m_reads));
    chk("cnt_writes", cnt_writes, exp_cnt(m_writes));
    chk("cnt_snoops", cnt_snoops, exp_cnt(m_snoops));
    chk("cnt_errs", cnt_errs, exp_cnt(m_errs));
  endtask

  task automatic drain();
    logic rdy, hs;
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      cycle(1'b0, 4'd0, 32'd0, 1'b1, rdy, hs);
      n++;
    end
    chk("drain_left", q.size(), 0);
    chk("drain_valid", out_valid, 1'b0);
  endtask

  initial begin
    logic rdy, hs;
    int   nhs;
    logic [3:0] c6;
    logic [31:0] a6;

    rst_n = 1'b0; in_valid = 1'b0; in_cmd = '0; in_addr = '0; out_ready = 1'b0;
    m_reads = 0; m_writes = 0; m_snoops = 0; m_errs = 0;
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_err", err_cmd, 1'b0);
    chk("rst_fields", {out_cmd, out_tag, out_index, out_offset}, '0);
    chk("rst_cnts", {cnt_reads, cnt_writes, cnt_snoops, cnt_errs}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", in_ready, 1'b1);
    @(negedge clk);

    // Single read with latency and explicit field values
    cycle(1'b1, 4'd0, 32'h1234_5678, 1'b1, rdy, hs);
    chk("lat_edge_n", out_valid, 1'b0);
    cycle(1'b0, 4'd0, 32'd0, 1'b0, rdy, hs);
    chk("lat_edge_n1", out_valid, 1'b1);
    chk("sr_tag", out_tag, 12'h123);
    chk("sr_index", out_index, 14'h1159);
    chk("sr_offset", out_offset, 6'h38);
    cycle(1'b0, 4'd0, 32'd0, 1'b1, rdy, hs);
    chk("sr_hs", hs, 1'b1);
    chk("sr_reads", cnt_reads, exp_cnt(1));
    drain();

    // Back-pressure fill: 5 accepted, then full
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, rand_legal(), $urandom, 1'b0, rdy, hs);
      chk("bp_accept", rdy, 1'b1);
    end
    #1;
    chk("bp_full_ready", in_ready, 1'b0);
    c6 = rand_legal(); a6 = $urandom;
    cycle(1'b1, c6, a6, 1'b1, rdy, hs);
    chk("bp_no_push_on_pop", rdy, 1'b0);
    chk("bp_hs0", hs, 1'b1);
    cycle(1'b1, c6, a6, 1'b1, rdy, hs);
    chk("bp_sixth_accept", rdy, 1'b1);
    chk("bp_hs1", hs, 1'b1);
    nhs = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 4'd0, 32'd0, 1'b1, rdy, hs);
      if (hs) nhs++;
    end
    chk("bp_back_to_back", nhs, 4);
    drain();

    // Illegal command followed by a write
    cycle(1'b1, 4'd7, 32'h0000_1111, 1'b1, rdy, hs);
    cycle(1'b1, 4'd1, 32'hFFFF_FFC0, 1'b1, rdy, hs);
    drain();
    chk("ill_errs", cnt_errs, exp_cnt(1));

    // Snoop, clear barrier, print
    cycle(1'b1, 4'd4, $urandom, 1'b1, rdy, hs);
    cycle(1'b1, 4'd8, 32'hDEAD_BEEF, 1'b1, rdy, hs);
    cycle(1'b1, 4'd9, $urandom, 1'b1, rdy, hs);
    drain();
    chk("clr_reads", cnt_reads, 0);
    chk("clr_errs_kept", cnt_errs, exp_cnt(1));

    // Random traffic with legal and illegal codes
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom,
            ($urandom_range(0, 9) < 7), rdy, hs);
    end
    drain();

    // Reset mid-stream with entries queued
    for (int i = 0; i < 3; i++)
      cycle(1'b1, rand_legal(), $urandom, 1'b0, rdy, hs);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_cnts", {cnt_reads, cnt_writes, cnt_snoops, cnt_errs}, '0);
    q.delete();
    m_reads = 0; m_writes = 0; m_snoops = 0; m_errs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_ready", in_ready, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 4'd0, 32'd0, 1'b1, rdy, hs);
    chk("mid_rst_no_stale", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
